// File: rtl/adsr_envelope.sv
// adsr_envelope: four-stage ADSR envelope generator, single clk domain.
// A sample tick is a rising edge of sample_clk seen in the clk domain.
// The tick edge updates the gate, state and accumulator. The output
// registers follow one clk later, and every value holds between ticks.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   sample_clk   sample strobe, synchronous to clk
//   sample_in0   gate input, with a hysteresis comparator
//   sample_in1   attack rate CV
//   sample_in2   decay / release rate CV
//   sample_in3   sustain level CV
//   sample_out0  envelope, 0..32767
//   sample_out1  inverted envelope, 32767 - sample_out0
//   sample_out2  end-of-attack trigger: 20000 for one sample period, else 0
//   sample_out3  state code x 4096 (IDLE=0, A=1, D=2, S=3, R=4)
module adsr_envelope #(
  parameter int W           = 16,
  parameter int GATE_THRESH = 4000,
  parameter int GATE_HYST   = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3
);

  localparam int ACC_W = W + 7;
  localparam logic [ACC_W-1:0]    ACC_MAX    = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0]    ACC_ZERO   = {ACC_W{1'b0}};
  localparam logic [ACC_W-1:0]    ACC_ONE    = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [W-1:0] THR_ON     = W'(GATE_THRESH);
  localparam logic signed [W-1:0] THR_OFF    = W'(GATE_THRESH - GATE_HYST);
  localparam logic [W-1:0]        FULL_SCALE = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]        EOA_LEVEL  = W'(32'd20000);
  localparam logic [W-1:0]        OUT_ZERO   = {W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Rate CV to per-tick step: max(cv, 0) + 1, so the step is always at least 1.
  function automatic logic [ACC_W-1:0] rate_step(input logic signed [W-1:0] cv);
    logic [ACC_W-1:0] s;
    if (cv[W-1]) begin
      s = ACC_ONE;
    end else begin
      s = {{(ACC_W-W){1'b0}}, cv} + ACC_ONE;
    end
    return s;
  endfunction

  // Add with one guard bit and clamp to ACC_MAX, so a step never wraps the accumulator.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
    logic [ACC_W:0] sum;
    logic [ACC_W-1:0] r;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, ACC_MAX}) begin
      r = ACC_MAX;
    end else begin
      r = sum[ACC_W-1:0];
    end
    return r;
  endfunction

  // Subtract and clamp at zero.
  function automatic logic [ACC_W-1:0] sat_sub(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] r;
    if (b >= a) begin
      r = ACC_ZERO;
    end else begin
      r = a - b;
    end
    return r;
  endfunction

  state_t           state_r, state_next_s;
  logic [ACC_W-1:0] acc_r, acc_next_s;
  logic             gate_r, gate_next_s;
  logic             eoa_r, eoa_next_s;
  logic             sample_clk_d_r;
  logic             tick_d_r;
  logic             tick_s;
  logic             gate_cmp_s;
  logic             rise_s, fall_s;
  logic [ACC_W-1:0] tgt_s, att_val_s, dec_val_s, rel_val_s;
  logic [W-1:0]     env_s;

  assign tick_s = sample_clk & ~sample_clk_d_r;
  assign env_s  = {1'b0, acc_r[ACC_W-1:8]};

  // Gate comparator, rate steps and candidate accumulator values for this tick.
  always_comb begin
    gate_cmp_s = gate_r;
    if (gate_r) begin
      gate_cmp_s = !(sample_in0 < THR_OFF);
    end else begin
      gate_cmp_s = (sample_in0 > THR_ON);
    end
    rise_s = gate_cmp_s & ~gate_r;
    fall_s = ~gate_cmp_s & gate_r;
    if (sample_in3[W-1]) begin
      tgt_s = ACC_ZERO;
    end else begin
      tgt_s = {sample_in3[W-2:0], 8'h00};
    end
    att_val_s = sat_add(acc_r, rate_step(sample_in1));
    dec_val_s = sat_sub(acc_r, rate_step(sample_in2));
    rel_val_s = dec_val_s;
  end

  // Next state, accumulator and end-of-attack flag. Gate edges take precedence over level-driven moves.
  always_comb begin
    state_next_s = state_r;
    acc_next_s   = acc_r;
    gate_next_s  = gate_r;
    eoa_next_s   = eoa_r;
    if (tick_s) begin
      gate_next_s = gate_cmp_s;
      eoa_next_s  = 1'b0;
      if (rise_s || (state_r == ST_ATTACK && !fall_s)) begin
        // A retrigger keeps the current level and steps up from there.
        if (att_val_s == ACC_MAX) begin
          acc_next_s   = ACC_MAX;
          state_next_s = ST_DECAY;
          eoa_next_s   = 1'b1;
        end else begin
          acc_next_s   = att_val_s;
          state_next_s = ST_ATTACK;
        end
      end else if (fall_s && (state_r == ST_ATTACK || state_r == ST_DECAY ||
                              state_r == ST_SUSTAIN || state_r == ST_RELEASE)) begin
        if (rel_val_s == ACC_ZERO) begin
          acc_next_s   = ACC_ZERO;
          state_next_s = ST_IDLE;
        end else begin
          acc_next_s   = rel_val_s;
          state_next_s = ST_RELEASE;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            acc_next_s = ACC_ZERO;
          end
          ST_DECAY: begin
            // This also covers an entry level already below the target.
            if (dec_val_s <= tgt_s) begin
              acc_next_s   = tgt_s;
              state_next_s = ST_SUSTAIN;
            end else begin
              acc_next_s = dec_val_s;
            end
          end
          ST_SUSTAIN: begin
            acc_next_s = tgt_s;
          end
          ST_RELEASE: begin
            if (rel_val_s == ACC_ZERO) begin
              acc_next_s   = ACC_ZERO;
              state_next_s = ST_IDLE;
            end else begin
              acc_next_s = rel_val_s;
            end
          end
          default: begin
            acc_next_s   = ACC_ZERO;
            state_next_s = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // State register: state, accumulator, gate, edge detector and tick delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      acc_r          <= ACC_ZERO;
      gate_r         <= 1'b0;
      eoa_r          <= 1'b0;
      sample_clk_d_r <= 1'b0;
      tick_d_r       <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      acc_r          <= acc_next_s;
      gate_r         <= gate_next_s;
      eoa_r          <= eoa_next_s;
      sample_clk_d_r <= sample_clk;
      tick_d_r       <= tick_s;
    end
  end

  // Output registers, loaded one clk after each tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_out0 <= OUT_ZERO;
      sample_out1 <= FULL_SCALE;
      sample_out2 <= OUT_ZERO;
      sample_out3 <= OUT_ZERO;
    end else if (tick_d_r) begin
      sample_out0 <= env_s;
      sample_out1 <= FULL_SCALE - env_s;
      sample_out2 <= eoa_r ? EOA_LEVEL : OUT_ZERO;
      sample_out3 <= {{(W-15){1'b0}}, state_r, 12'h000};
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope. A reference model predicts the
// outputs of each tick and queues them before the tick is driven. The queued
// values are compared once the DUT has registered its outputs.
module tb_adsr_envelope;

  localparam longint ACC_MAX = 64'd8388607;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_clk = 1'b0;
  logic signed [15:0] in0 = 16'sd0, in1 = 16'sd0, in2 = 16'sd0, in3 = 16'sd0;
  logic signed [15:0] out0, out1, out2, out3;

  int checks = 0;
  int errors = 0;

  typedef struct { int o0; int o1; int o2; int o3; } exp_t;
  exp_t sb_q[$];

  int     m_state;
  longint m_acc;
  bit     m_gate;
  bit     m_eoa;

  adsr_envelope dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk),
    .sample_in0(in0), .sample_in1(in1), .sample_in2(in2), .sample_in3(in3),
    .sample_out0(out0), .sample_out1(out1), .sample_out2(out2), .sample_out3(out3)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_acc = 0; m_gate = 1'b0; m_eoa = 1'b0;
    sb_q.delete();
  endtask

  // Reference model: advance one tick with the current inputs and queue the expected outputs.
  task automatic model_step();
    int c0, c1, c2, c3;
    bit g, rise, fall;
    longint s1, s2, tgt, a;
    exp_t e;
    c0 = in0; c1 = in1; c2 = in2; c3 = in3;
    g = m_gate ? !(c0 < 3000) : (c0 > 4000);
    rise = g && !m_gate;
    fall = !g && m_gate;
    m_gate = g;
    s1 = (c1 > 0 ? c1 : 0) + 1;
    s2 = (c2 > 0 ? c2 : 0) + 1;
    tgt = (c3 > 0 ? c3 : 0) * 256;
    m_eoa = 1'b0;
    if (rise) m_state = 1;
    else if (fall && m_state >= 1 && m_state <= 3) m_state = 4;
    else if (m_state == 4 && fall) m_state = 4;
    if (m_state == 1) begin
      a = m_acc + s1;
      if (a >= ACC_MAX) begin m_acc = ACC_MAX; m_state = 2; m_eoa = 1'b1; end
      else m_acc = a;
    end else if (m_state == 2) begin
      a = m_acc - s2;
      if (a <= tgt) begin m_acc = tgt; m_state = 3; end
      else m_acc = a;
    end else if (m_state == 3) begin
      m_acc = tgt;
    end else if (m_state == 4) begin
      a = m_acc - s2;
      if (a <= 0) begin m_acc = 0; m_state = 0; end
      else m_acc = a;
    end else begin
      m_acc = 0;
    end
    e.o0 = int'(m_acc >> 8);
    e.o1 = 32767 - e.o0;
    e.o2 = m_eoa ? 20000 : 0;
    e.o3 = m_state * 4096;
    sb_q.push_back(e);
  endtask

  // One sample tick: predict, strobe sample_clk, wait for the output registers, compare.
  task automatic do_tick();
    exp_t e;
    model_step();
    @(negedge clk) sample_clk = 1'b1;
    @(negedge clk) sample_clk = 1'b0;
    @(negedge clk);
    e = sb_q.pop_front();
    checks += 4;
    if (out0 !== 16'(e.o0)) begin errors++; $display("FAIL sb_out0 got %0d exp %0d", out0, e.o0); end
    if (out1 !== 16'(e.o1)) begin errors++; $display("FAIL sb_out1 got %0d exp %0d", out1, e.o1); end
    if (out2 !== 16'(e.o2)) begin errors++; $display("FAIL sb_out2 got %0d exp %0d", out2, e.o2); end
    if (out3 !== 16'(e.o3)) begin errors++; $display("FAIL sb_out3 got %0d exp %0d", out3, e.o3); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks += 4;
    if (out0 !== 16'sd0)     begin errors++; $display("FAIL reset_out0 got %0d exp 0", out0); end
    if (out1 !== 16'sd32767) begin errors++; $display("FAIL reset_out1 got %0d exp 32767", out1); end
    if (out2 !== 16'sd0)     begin errors++; $display("FAIL reset_out2 got %0d exp 0", out2); end
    if (out3 !== 16'sd0)     begin errors++; $display("FAIL reset_out3 got %0d exp 0", out3); end
  endtask

  task automatic test_attack();
    in0 = 16'sd10000; in1 = 16'sd32767; in2 = 16'sd32767; in3 = 16'sd16384;
    do_tick();
    checks += 2;
    if (out3 !== 16'sd4096) begin errors++; $display("FAIL attack_start_state got %0d exp 4096", out3); end
    if (out0 !== 16'sd128)  begin errors++; $display("FAIL attack_first_step got %0d exp 128", out0); end
    repeat (254) do_tick();
    checks++;
    if (out0 !== 16'sd32640) begin errors++; $display("FAIL attack_tick255 got %0d exp 32640", out0); end
    do_tick();
    checks += 3;
    if (out0 !== 16'sd32767) begin errors++; $display("FAIL attack_peak got %0d exp 32767", out0); end
    if (out2 !== 16'sd20000) begin errors++; $display("FAIL eoa_pulse got %0d exp 20000", out2); end
    if (out3 !== 16'sd8192)  begin errors++; $display("FAIL decay_entry got %0d exp 8192", out3); end
    do_tick();
    checks++;
    if (out2 !== 16'sd0) begin errors++; $display("FAIL eoa_clear got %0d exp 0", out2); end
  endtask

  task automatic test_decay_sustain();
    repeat (126) do_tick();
    checks++;
    if (out3 !== 16'sd8192) begin errors++; $display("FAIL decay_still got %0d exp 8192", out3); end
    do_tick();
    checks += 2;
    if (out0 !== 16'sd16384) begin errors++; $display("FAIL sustain_level got %0d exp 16384", out0); end
    if (out3 !== 16'sd12288) begin errors++; $display("FAIL sustain_state got %0d exp 12288", out3); end
    in3 = 16'sd8192;
    do_tick();
    checks++;
    if (out0 !== 16'sd8192) begin errors++; $display("FAIL sustain_track got %0d exp 8192", out0); end
    in3 = 16'sd16384;
    do_tick();
  endtask

  task automatic test_release();
    in0 = 16'sd0;
    do_tick();
    checks += 2;
    if (out3 !== 16'sd16384) begin errors++; $display("FAIL release_state got %0d exp 16384", out3); end
    if (out0 !== 16'sd16256) begin errors++; $display("FAIL release_first got %0d exp 16256", out0); end
    repeat (126) do_tick();
    checks++;
    if (out3 !== 16'sd16384) begin errors++; $display("FAIL release_still got %0d exp 16384", out3); end
    do_tick();
    checks += 2;
    if (out3 !== 16'sd0) begin errors++; $display("FAIL release_idle got %0d exp 0", out3); end
    if (out0 !== 16'sd0) begin errors++; $display("FAIL release_zero got %0d exp 0", out0); end
  endtask

  task automatic test_hysteresis();
    int seq[4];
    int exp3[4];
    int attacks, releases;
    logic signed [15:0] prev;
    seq  = '{4500, 3500, 2900, 3500};
    exp3 = '{4096, 4096, 16384, 16384};
    attacks = 0; releases = 0; prev = out3;
    in1 = 16'sd100; in2 = -16'sd1;
    for (int i = 0; i < 4; i++) begin
      in0 = 16'(seq[i]);
      do_tick();
      checks++;
      if (out3 !== 16'(exp3[i])) begin errors++; $display("FAIL hyst_state_%0d got %0d exp %0d", i, out3, exp3[i]); end
      if (out3 == 16'sd4096 && prev != 16'sd4096) attacks++;
      if (out3 == 16'sd16384 && prev != 16'sd16384) releases++;
      prev = out3;
    end
    checks += 2;
    if (attacks != 1)  begin errors++; $display("FAIL hyst_attacks got %0d exp 1", attacks); end
    if (releases != 1) begin errors++; $display("FAIL hyst_releases got %0d exp 1", releases); end
    in0 = 16'sd0; in2 = 16'sd32767;
    do_tick();
    checks++;
    if (out3 !== 16'sd0) begin errors++; $display("FAIL hyst_idle got %0d exp 0", out3); end
  endtask

  task automatic test_negative_rate();
    in0 = 16'sd10000; in1 = -16'sd5000;
    repeat (10) do_tick();
    checks += 2;
    if (out0 !== 16'sd0)    begin errors++; $display("FAIL negrate_out0 got %0d exp 0", out0); end
    if (out3 !== 16'sd4096) begin errors++; $display("FAIL negrate_state got %0d exp 4096", out3); end
    in1 = 16'sd32767;
    repeat (39) do_tick();
    in1 = 16'sd2038;
    do_tick();
    in0 = 16'sd0; in2 = -16'sd1;
    do_tick();
    checks += 2;
    if (out0 !== 16'sd5000)  begin errors++; $display("FAIL retrig_pre_level got %0d exp 5000", out0); end
    if (out3 !== 16'sd16384) begin errors++; $display("FAIL retrig_pre_state got %0d exp 16384", out3); end
    in0 = 16'sd10000; in1 = -16'sd5000;
    do_tick();
    checks += 2;
    if (out0 !== 16'sd5000) begin errors++; $display("FAIL retrig_level got %0d exp 5000", out0); end
    if (out3 !== 16'sd4096) begin errors++; $display("FAIL retrig_state got %0d exp 4096", out3); end
  endtask

  task automatic test_reset_mid_sustain();
    int budget;
    in1 = 16'sd32767; in2 = 16'sd32767; in3 = 16'sd32767;
    budget = 0;
    while (out3 !== 16'sd12288 && budget < 400) begin
      do_tick();
      budget++;
    end
    checks++;
    if (out3 !== 16'sd12288) begin errors++; $display("FAIL reach_sustain got %0d exp 12288", out3); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (out0 !== 16'sd0)     begin errors++; $display("FAIL midreset_out0 got %0d exp 0", out0); end
    if (out1 !== 16'sd32767) begin errors++; $display("FAIL midreset_out1 got %0d exp 32767", out1); end
    if (out3 !== 16'sd0)     begin errors++; $display("FAIL midreset_out3 got %0d exp 0", out3); end
    rst = 1'b0;
    model_reset();
    in0 = 16'sd0;
    do_tick();
  endtask

  initial begin
    test_reset();
    test_attack();
    test_decay_sustain();
    test_release();
    test_hysteresis();
    test_negative_rate();
    test_reset_mid_sustain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
